// File: rtl/tagger_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tagger_drive_ctrl
//
// This block drives movement for the tagger sprite. Raw push-buttons are
// synchronised and then debounced on frame pulses. Each debounced rising edge
// becomes a one-cycle press event. A small FSM (INIT/LOAD/IDLE/RUN) turns
// those press events into latched direction levels and centre-load strobes.
// Wall-collision flags gate the direction outputs so the sprite never moves
// into a wall.
//
// Optional feature macro: TAGGER_DIAGONAL_EN
//   When defined, the vertical axis (Up/Down) and the horizontal axis
//   (Left/Right) are latched independently.
//
// Parameters
//   DEBOUNCE_FRAMES  frame samples a new level must hold before it is
//                    accepted (1..15)
//   SYNC_STAGES      synchroniser depth on each raw button (2..3)
//
// Ports
//   clk, resetN                      clock, asynchronous active-low reset
//   frame                            one-cycle pulse per video frame
//   btnUp/Down/Left/Right/Center     raw asynchronous buttons, active-high
//   topHit/bottomHit/leftHit/rightHit  wall-collision levels from the sprite
//   gameOver                         level, forces a halt
//   cntUp/Down/Left/Right            movement direction levels
//   upDownLD, leftRightLD            load-to-centre strobes
//   moving                           high while any cnt* output is high
//   state                            FSM state (INIT=0 LOAD=1 IDLE=2 RUN=3)
// -----------------------------------------------------------------------------
module tagger_drive_ctrl #(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       frame,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnCenter,
  input  logic       topHit,
  input  logic       bottomHit,
  input  logic       leftHit,
  input  logic       rightHit,
  input  logic       gameOver,
  output logic       cntUp,
  output logic       cntDown,
  output logic       cntLeft,
  output logic       cntRight,
  output logic       upDownLD,
  output logic       leftRightLD,
  output logic       moving,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_IDLE = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // The counter reaches DB_LAST on the last mismatching sample before the
  // new level is accepted.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES - 1);

  // Bit order for buttons: 0 Up, 1 Down, 2 Left, 3 Right, 4 Center.
  // Direction and hit vectors use the same order for bits 0..3.
  logic [4:0] btn_raw;
  logic [4:0] db;
  logic [4:0] db_dly;
  logic [4:0] press;
  logic [3:0] hit;

  assign btn_raw = {btnCenter, btnRight, btnLeft, btnDown, btnUp};
  assign hit     = {rightHit, leftHit, bottomHit, topHit};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [3:0]             cnt_reg;
      logic                   db_reg;
      logic                   db_dly_reg;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
        end
      end

      // The counter only moves on frame. Any sample that agrees with the
      // accepted level restarts the count.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          cnt_reg    <= '0;
          db_reg     <= 1'b0;
          db_dly_reg <= 1'b0;
        end else begin
          db_dly_reg <= db_reg;
          if (frame) begin
            if (sync_reg[SYNC_STAGES-1] == db_reg) begin
              cnt_reg <= '0;
            end else if (cnt_reg == DB_LAST) begin
              db_reg  <= sync_reg[SYNC_STAGES-1];
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
      end

      assign db[gi]     = db_reg;
      assign db_dly[gi] = db_dly_reg;
    end
  endgenerate

  // A press event is asserted for exactly one cycle per rising edge of the
  // debounced level.
  assign press = db & ~db_dly;

  state_t     state_reg, state_next;
  logic [3:0] dir_reg, dir_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= ST_INIT;
      dir_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    // By default a set bit is dropped once its wall is touched. A press in
    // the same cycle overrides this below.
    dir_next   = dir_reg & ~hit;
    case (state_reg)
      ST_INIT: state_next = ST_LOAD;
      ST_LOAD: begin
        state_next = ST_IDLE;
        dir_next   = '0;
      end
      ST_IDLE: begin
        if (press[4] && !gameOver) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (gameOver || press[4]) state_next = ST_LOAD;
`ifdef TAGGER_DIAGONAL_EN
        if (press[0])      dir_next[1:0] = 2'b01;
        else if (press[1]) dir_next[1:0] = 2'b10;
        if (press[2])      dir_next[3:2] = 2'b01;
        else if (press[3]) dir_next[3:2] = 2'b10;
`else
        if (press[0])      dir_next = 4'b0001;
        else if (press[1]) dir_next = 4'b0010;
        else if (press[2]) dir_next = 4'b0100;
        else if (press[3]) dir_next = 4'b1000;
`endif
      end
      default: state_next = ST_INIT;
    endcase
  end

  // The hit flag gates the output combinationally, so a direction stops in
  // the very cycle its wall is touched.
  logic [3:0] cnt;
  assign cnt = dir_reg & ~hit & {4{state_reg == ST_RUN}};

  assign cntUp       = cnt[0];
  assign cntDown     = cnt[1];
  assign cntLeft     = cnt[2];
  assign cntRight    = cnt[3];
  assign moving      = |cnt;
  assign upDownLD    = (state_reg == ST_LOAD);
  assign leftRightLD = (state_reg == ST_LOAD);
  assign state       = state_reg;

endmodule

// File: tb/tb_tagger_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tagger_drive_ctrl
//
// Directed-vector bench for tagger_drive_ctrl. It uses the default parameters
// (3 debounce frames, 2 sync stages). Inputs are driven 1 ns after the rising
// edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tagger_drive_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       frame = 1'b0;
  logic [4:0] btn = '0;      // 0 Up, 1 Down, 2 Left, 3 Right, 4 Center
  logic [3:0] hit = '0;      // 0 top, 1 bottom, 2 left, 3 right
  logic       gameOver = 1'b0;
  logic       cntUp, cntDown, cntLeft, cntRight;
  logic       upDownLD, leftRightLD, moving;
  logic [1:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tagger_drive_ctrl dut (
    .clk(clk), .resetN(resetN), .frame(frame),
    .btnUp(btn[0]), .btnDown(btn[1]), .btnLeft(btn[2]), .btnRight(btn[3]),
    .btnCenter(btn[4]),
    .topHit(hit[0]), .bottomHit(hit[1]), .leftHit(hit[2]), .rightHit(hit[3]),
    .gameOver(gameOver),
    .cntUp(cntUp), .cntDown(cntDown), .cntLeft(cntLeft), .cntRight(cntRight),
    .upDownLD(upDownLD), .leftRightLD(leftRightLD), .moving(moving),
    .state(state)
  );

  // Packed view of outputs: {cntRight, cntLeft, cntDown, cntUp}
  logic [3:0] cnt_obs;
  logic [1:0] ld_obs;
  assign cnt_obs = {cntRight, cntLeft, cntDown, cntUp};
  assign ld_obs  = {upDownLD, leftRightLD};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two idle cycles let the synchroniser settle, then one frame pulse.
  task automatic frame_pulse();
    step();
    step();
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  // Drive a button level and apply enough frames for it to be accepted.
  // On return the debounced level has just changed. For a rising level the
  // press event is active now, and the register update happens on the next
  // edge.
  task automatic debounce_to(input int idx, input logic level);
    btn[idx] = level;
    for (int i = 0; i < 3; i++) frame_pulse();
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_state", state, 2'd0);
    check("reset_cnt", cnt_obs, 4'h0);
    check("reset_ld", ld_obs, 2'b00);
    check("reset_moving", moving, 1'b0);

    // Release: INIT -> LOAD -> IDLE
    @(posedge clk); #1;
    resetN = 1'b1;
    check("init_state", state, 2'd0);
    step();
    check("load_state", state, 2'd1);
    check("load_ld", ld_obs, 2'b11);
    step();
    check("idle_state", state, 2'd2);
    check("idle_ld", ld_obs, 2'b00);
    check("idle_cnt", cnt_obs, 4'h0);

    // Centre held only 2 frames, then released: no transition
    btn[4] = 1'b1;
    frame_pulse();
    frame_pulse();
    btn[4] = 1'b0;
    frame_pulse();
    step(); step();
    check("short_press_idle", state, 2'd2);

    // Centre held 3 frames: IDLE -> RUN
    debounce_to(4, 1'b1);
    check("center_pre_edge", state, 2'd2);
    step();
    check("center_run", state, 2'd3);
    check("run_cnt_zero", cnt_obs, 4'h0);
    debounce_to(4, 1'b0);
    check("center_release_run", state, 2'd3);

    // Right press, then right wall hit
    debounce_to(3, 1'b1);
    check("right_pre_edge", cnt_obs, 4'h0);
    step();
    check("right_cnt", cnt_obs, 4'b1000);
    check("right_moving", moving, 1'b1);
    hit[3] = 1'b1;
    #1;
    check("right_hit_gate", cnt_obs, 4'h0);
    check("right_hit_moving", moving, 1'b0);
    step();
    hit[3] = 1'b0;
    #1;
    check("right_dir_cleared", cnt_obs, 4'h0);
    debounce_to(3, 1'b0);

    // Up and Left accepted in the same cycle
    btn[0] = 1'b1;
    debounce_to(2, 1'b1);
    step();
`ifdef TAGGER_DIAGONAL_EN
    check("up_left_diag", cnt_obs, 4'b0101);
`else
    check("up_left_prio", cnt_obs, 4'b0001);
`endif
    btn[0] = 1'b0;
    debounce_to(2, 1'b0);

    // Down press, wall hit clears it, then a press into the wall is latched
    // (press wins over clear) but gated until the wall flag drops.
    debounce_to(1, 1'b1);
    step();
    check("down_cnt", cnt_obs, 4'b0010);
    hit[1] = 1'b1;
    debounce_to(1, 1'b0);
    debounce_to(1, 1'b1);
    step();
    check("down_into_wall_gated", cnt_obs, 4'h0);
    hit[1] = 1'b0;
    #1;
    check("down_latched", cnt_obs, 4'b0010);
    debounce_to(1, 1'b0);
    check("down_hold_after_release", cnt_obs, 4'b0010);

    // gameOver in RUN: one LOAD, then held in IDLE
    gameOver = 1'b1;
    step();
    check("go_load", state, 2'd1);
    check("go_ld", ld_obs, 2'b11);
    check("go_cnt", cnt_obs, 4'h0);
    step();
    check("go_idle", state, 2'd2);
    check("go_ld_off", ld_obs, 2'b00);
    debounce_to(4, 1'b1);
    step(); step();
    check("go_center_ignored", state, 2'd2);
    debounce_to(4, 1'b0);
    gameOver = 1'b0;

    // Back to RUN, latch Down, then asynchronous reset mid-cycle
    debounce_to(4, 1'b1);
    step();
    check("rerun_state", state, 2'd3);
    debounce_to(4, 1'b0);
    debounce_to(1, 1'b1);
    step();
    check("pre_reset_down", cnt_obs, 4'b0010);
    btn[1] = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_cnt", cnt_obs, 4'h0);
    check("async_rst_state", state, 2'd0);
    check("async_rst_moving", moving, 1'b0);
    @(posedge clk); #1;
    resetN = 1'b1;
    step();
    check("rst2_load", state, 2'd1);
    check("rst2_ld", ld_obs, 2'b11);
    step();
    check("rst2_idle", state, 2'd2);
    check("rst2_cnt", cnt_obs, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
